// File: rtl/mult4_pkg.sv
// Shared definitions for the 4-bit multiplier datapath: product width, FSM states
// and the sign-extend / clamp helpers used by the saturating accumulator.
package mult4_pkg;

  localparam int PROD_W = 4;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int sext_prod(input logic [PROD_W-1:0] y);
    return int'(signed'(y));
  endfunction

  // Clamp to the signed range of a w-bit two's-complement value (w <= 31).
  function automatic int clamp_int(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mult4_accumulator_if.sv
// Term input stream and frame result stream of the accumulator.
interface mult4_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic [mult4_pkg::PROD_W-1:0]  in_y;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_W-1:0]       out_sum;
  logic [CNT_W-1:0]              out_count;
  logic                          out_sat;

  modport master (
    output in_valid, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_y, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/mult4_accumulator_sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus sign-extended product.
module sat_add
  import mult4_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic [PROD_W-1:0]       i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  int w_wide;
  int w_clamped;

  // Exact sum fits easily in 32 bits for any ACC_W up to 30.
  always_comb begin
    w_wide    = int'(i_a) + sext_prod(i_b);
    w_clamped = clamp_int(w_wide, ACC_W);
    o_ovf     = (w_clamped != w_wide);
    o_sum     = ACC_W'(w_clamped);
  end

endmodule

// File: rtl/mult4_accumulator.sv
// Frame accumulator behind the 4-bit signed multiplier: sums products with
// saturation and emits sum, term count and sticky saturation flag per frame.
module mult4_accumulator
  import mult4_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  mult4_accumulator_if.slave  bus
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sat;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_sat;

  logic                    w_in_ready;
  logic                    w_take;
  logic                    w_close;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .i_a   (r_acc),
    .i_b   (bus.in_y),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_in_ready = i_rst_n & (r_state == ACCUM);
  // clear beats a term offered in the same cycle
  assign w_take     = bus.in_valid & w_in_ready & ~i_clear;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_close    = w_take & (bus.in_last | (w_cnt_inc == CNT_W'(MAX_TERMS)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ACCUM;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: if (w_close) w_state_nxt = HOLD;
      HOLD:  if (bus.out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_close) begin
        r_out_sum   <= w_sum;
        r_out_count <= w_cnt_inc;
        r_out_sat   <= r_sat | w_ovf;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_sat       <= 1'b0;
      end else if (w_take) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
        r_sat <= r_sat | w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_mult4_accumulator.sv
// Bench for mult4_accumulator: two instances (MAX_TERMS 16 and 32), a frame-level
// model compared every cycle, plus directed literal expectations.
module tb_mult4_accumulator;

  localparam int MAXT_A = 16;
  localparam int MAXT_B = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  always #5 clk = ~clk;

  mult4_accumulator_if #(.ACC_W(8), .CNT_W(5)) ifa ();
  mult4_accumulator_if #(.ACC_W(8), .CNT_W(6)) ifb ();

  mult4_accumulator #(.ACC_W(8), .MAX_TERMS(MAXT_A)) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (ifa)
  );

  mult4_accumulator #(.ACC_W(8), .MAX_TERMS(MAXT_B)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (ifb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Frame model: running sum/count/sat, pending result and whether one is held.
  int m_sum[2];
  int m_cnt[2];
  bit m_sat[2];
  bit m_hold[2];
  int m_osum[2];
  int m_ocnt[2];
  bit m_osat[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input int k, input int maxt, input logic v,
                            input logic [3:0] y, input logic l, input logic ordy);
    int s;
    if (!rst_n) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_hold[k] = 0;
      m_osum[k] = 0; m_ocnt[k] = 0; m_osat[k] = 0;
    end else if (m_hold[k]) begin
      if (ordy) m_hold[k] = 0;
    end else if (clear) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
    end else if (v) begin
      s = m_sum[k] + int'($signed(y));
      if (s > 127)  begin s = 127;  m_sat[k] = 1; end
      if (s < -128) begin s = -128; m_sat[k] = 1; end
      m_sum[k] = s;
      m_cnt[k] = m_cnt[k] + 1;
      if (l || m_cnt[k] == maxt) begin
        m_osum[k] = m_sum[k]; m_ocnt[k] = m_cnt[k]; m_osat[k] = m_sat[k];
        m_sum[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_hold[k] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, MAXT_A, ifa.in_valid, ifa.in_y, ifa.in_last, ifa.out_ready);
    model_step(1, MAXT_B, ifb.in_valid, ifb.in_y, ifb.in_last, ifb.out_ready);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_in_ready",  int'(ifa.in_ready),  int'(rst_n && !m_hold[0]));
      chk("a_out_valid", int'(ifa.out_valid), int'(m_hold[0]));
      chk("a_out_sum",   int'(ifa.out_sum),   m_osum[0]);
      chk("a_out_count", int'(ifa.out_count), m_ocnt[0]);
      chk("a_out_sat",   int'(ifa.out_sat),   int'(m_osat[0]));
      chk("b_in_ready",  int'(ifb.in_ready),  int'(rst_n && !m_hold[1]));
      chk("b_out_valid", int'(ifb.out_valid), int'(m_hold[1]));
      chk("b_out_sum",   int'(ifb.out_sum),   m_osum[1]);
      chk("b_out_count", int'(ifb.out_count), m_ocnt[1]);
      chk("b_out_sat",   int'(ifb.out_sat),   int'(m_osat[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, input int budget);
    int n;
    n = 0;
    while (!(k == 0 ? ifa.out_valid : ifb.out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_out_valid_timeout", n, 0);
  endtask

  task automatic ack(input int k);
    if (k == 0) ifa.out_ready = 1'b1; else ifb.out_ready = 1'b1;
    tick();
    if (k == 0) ifa.out_ready = 1'b0; else ifb.out_ready = 1'b0;
  endtask

  task automatic send_a(input logic [3:0] y, input logic l);
    ifa.in_valid = 1'b1; ifa.in_y = y; ifa.in_last = l;
    tick();
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_y = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_y = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_in_ready",  int'(ifa.in_ready), 0);
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_out_sum",   int'(ifa.out_sum), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", int'(ifa.in_ready), 1);

    // Single -3 term with last
    send_a(4'hD, 1'b1);
    chk("t1_valid", int'(ifa.out_valid), 1);
    chk("t1_sum",   int'(ifa.out_sum), -3);
    chk("t1_count", int'(ifa.out_count), 1);
    chk("t1_sat",   int'(ifa.out_sat), 0);
    ack(0);
    chk("t1_after_ack_valid", int'(ifa.out_valid), 0);
    chk("t1_keep_sum", int'(ifa.out_sum), -3);

    // 16 x +1, auto close
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1'b1; ifa.in_y = 4'd1; ifa.in_last = 1'b0;
      tick();
    end
    ifa.in_valid = 1'b0;
    wait_valid(0, 4);
    chk("t2_sum",   int'(ifa.out_sum), 16);
    chk("t2_count", int'(ifa.out_count), 16);
    tick(); tick();
    chk("t2_in_ready_held", int'(ifa.in_ready), 0);
    ack(0);

    // 17 x +7: frame closes at 16, 17th (last) waits and starts frame 2
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1'b1; ifa.in_y = 4'd7; ifa.in_last = 1'b0;
      tick();
    end
    ifa.in_last = 1'b1;
    chk("t3_f1_sum",   int'(ifa.out_sum), 112);
    chk("t3_f1_count", int'(ifa.out_count), 16);
    chk("t3_f1_sat",   int'(ifa.out_sat), 0);
    ack(0);
    tick();
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    wait_valid(0, 4);
    chk("t3_f2_sum",   int'(ifa.out_sum), 7);
    chk("t3_f2_count", int'(ifa.out_count), 1);
    ack(0);

    // 17 x -8 on the 32-term instance: saturates at -128
    for (int i = 0; i < 17; i++) begin
      ifb.in_valid = 1'b1; ifb.in_y = 4'h8; ifb.in_last = (i == 16);
      tick();
    end
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    wait_valid(1, 4);
    chk("t4_sum",   int'(ifb.out_sum), -128);
    chk("t4_count", int'(ifb.out_count), 17);
    chk("t4_sat",   int'(ifb.out_sat), 1);
    ack(1);
    ifb.in_valid = 1'b1; ifb.in_y = 4'd1; ifb.in_last = 1'b1;
    tick();
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    chk("t4_next_sum", int'(ifb.out_sum), 1);
    chk("t4_next_sat", int'(ifb.out_sat), 0);
    ack(1);

    // Backpressure for 5 cycles, with a clear during HOLD that must be ignored
    send_a(4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      tick();
      chk("t5_hold_sum",   int'(ifa.out_sum), 3);
      chk("t5_hold_ready", int'(ifa.in_ready), 0);
    end
    clear = 1'b0;
    ack(0);
    chk("t5_release_ready", int'(ifa.in_ready), 1);

    // Clear drops the partial frame and the term offered with it
    for (int i = 0; i < 3; i++) send_a(4'd2, 1'b0);
    clear = 1'b1;
    send_a(4'd5, 1'b0);
    clear = 1'b0;
    send_a(4'd1, 1'b1);
    chk("t6_sum",   int'(ifa.out_sum), 1);
    chk("t6_count", int'(ifa.out_count), 1);

    // Reset while holding a result
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", int'(ifa.out_valid), 0);
    chk("t6_rst_sum",   int'(ifa.out_sum), 0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
